// File: rtl/perceptron_sequencer.sv
// Feeds stored 5x5 binary patterns one at a time into a perceptron classifier,
// collects one verdict per pattern and keeps per-class tallies for the batch.
module perceptron_sequencer #(
    parameter int unsigned WIDTH   = 25,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 100,
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned ACC_W  = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_patterns_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] p_in_o,
    output logic             p_en_o,
    input  logic             p_ready_i,
    input  logic [1:0]       p_out_i,
    input  logic [ACC_W-1:0] p_acc_i,
    output logic             res_valid_o,
    output logic [IDX_W-1:0] res_idx_o,
    output logic [1:0]       res_class_o,
    output logic [ACC_W-1:0] res_acc_o,
    output logic             res_timeout_o,
    output logic [CNT_W-1:0] cross_cnt_o,
    output logic [CNT_W-1:0] circle_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  DepthCnt  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IdxOne    = IDX_W'(1);
    localparam logic [WAIT_W-1:0] WaitOne   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WaitLast  = WAIT_W'(TIMEOUT - 1);
    localparam logic [1:0]        ClsCross  = 2'b11;
    localparam logic [1:0]        ClsCircle = 2'b10;

    typedef enum logic [2:0] {StIdle, StFetch, StRun, StCapture, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [WIDTH-1:0]   p_in_q, p_in_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;
    logic [1:0]         res_class_q, res_class_d;
    logic [ACC_W-1:0]   res_acc_q, res_acc_d;
    logic               res_timeout_q, res_timeout_d;
    logic [CNT_W-1:0]   cross_q, cross_d;
    logic [CNT_W-1:0]   circle_q, circle_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic               busy_q, done_q, p_en_q, res_valid_q;

    // Pattern buffer is deliberately left out of reset.
    logic [WIDTH-1:0]   pat_q [DEPTH];

    logic [CNT_W-1:0]   n_clamped;
    logic [CNT_W-1:0]   idx_next_cnt;

    assign n_clamped    = (num_patterns_i > DepthCnt) ? DepthCnt : num_patterns_i;
    assign idx_next_cnt = CNT_W'(idx_q) + CntOne;

    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == StIdle)) begin
            pat_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        num_d         = num_q;
        wait_d        = wait_q;
        p_in_d        = p_in_q;
        res_idx_d     = res_idx_q;
        res_class_d   = res_class_q;
        res_acc_d     = res_acc_q;
        res_timeout_d = res_timeout_q;
        cross_d       = cross_q;
        circle_d      = circle_q;
        err_d         = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    num_d    = n_clamped;
                    idx_d    = '0;
                    cross_d  = '0;
                    circle_d = '0;
                    err_d    = '0;
                    state_d  = (n_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                p_in_d  = pat_q[idx_q];
                wait_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                // A ready arriving on the last allowed cycle still wins over the timeout.
                if (p_ready_i) begin
                    res_idx_d     = idx_q;
                    res_class_d   = p_out_i;
                    res_acc_d     = p_acc_i;
                    res_timeout_d = 1'b0;
                    state_d       = StCapture;
                end else if (wait_q == WaitLast) begin
                    res_idx_d     = idx_q;
                    res_class_d   = 2'b00;
                    res_acc_d     = '0;
                    res_timeout_d = 1'b1;
                    state_d       = StCapture;
                end else begin
                    wait_d = wait_q + WaitOne;
                end
            end
            StCapture: begin
                if (!res_timeout_q && (res_class_q == ClsCross)) begin
                    cross_d = cross_q + CntOne;
                end else if (!res_timeout_q && (res_class_q == ClsCircle)) begin
                    circle_d = circle_q + CntOne;
                end else begin
                    err_d = err_q + CntOne;
                end
                if (idx_next_cnt < num_q) begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StFetch;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards any in-flight result and leaves the tallies untouched.
        if (abort_i && (state_q != StIdle)) begin
            state_d       = StIdle;
            res_idx_d     = res_idx_q;
            res_class_d   = res_class_q;
            res_acc_d     = res_acc_q;
            res_timeout_d = res_timeout_q;
            cross_d       = cross_q;
            circle_d      = circle_q;
            err_d         = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            num_q         <= '0;
            wait_q        <= '0;
            p_in_q        <= '0;
            res_idx_q     <= '0;
            res_class_q   <= '0;
            res_acc_q     <= '0;
            res_timeout_q <= 1'b0;
            cross_q       <= '0;
            circle_q      <= '0;
            err_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            p_en_q        <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            num_q         <= num_d;
            wait_q        <= wait_d;
            p_in_q        <= p_in_d;
            res_idx_q     <= res_idx_d;
            res_class_q   <= res_class_d;
            res_acc_q     <= res_acc_d;
            res_timeout_q <= res_timeout_d;
            cross_q       <= cross_d;
            circle_q      <= circle_d;
            err_q         <= err_d;
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_d == StDone);
            p_en_q        <= (state_d == StRun);
            res_valid_q   <= (state_d == StCapture);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign p_in_o        = p_in_q;
    assign p_en_o        = p_en_q;
    assign res_valid_o   = res_valid_q;
    assign res_idx_o     = res_idx_q;
    assign res_class_o   = res_class_q;
    assign res_acc_o     = res_acc_q;
    assign res_timeout_o = res_timeout_q;
    assign cross_cnt_o   = cross_q;
    assign circle_cnt_o  = circle_q;
    assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Directed bench for perceptron_sequencer with a behavioural perceptron stand-in.
module tb_perceptron_sequencer;

    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [24:0] wr_data = '0;
    logic        start = 1'b0;
    logic [3:0]  num_patterns = '0;
    logic        abort = 1'b0;
    logic        busy, done, p_en, p_ready, res_valid, res_timeout;
    logic [24:0] p_in;
    logic [1:0]  p_out, res_class;
    logic [4:0]  p_acc, res_acc;
    logic [2:0]  res_idx;
    logic [3:0]  cross_cnt, circle_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    perceptron_sequencer #(.WIDTH(25), .DEPTH(8), .TIMEOUT(100)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .start_i(start), .num_patterns_i(num_patterns),
        .abort_i(abort), .busy_o(busy), .done_o(done), .p_in_o(p_in), .p_en_o(p_en),
        .p_ready_i(p_ready), .p_out_i(p_out), .p_acc_i(p_acc), .res_valid_o(res_valid),
        .res_idx_o(res_idx), .res_class_o(res_class), .res_acc_o(res_acc),
        .res_timeout_o(res_timeout), .cross_cnt_o(cross_cnt), .circle_cnt_o(circle_cnt),
        .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    // Perceptron stand-in: ready LAT cycles after en rises, verdict looked up from p_in.
    logic model_on = 1'b1;
    int   model_cnt;
    logic ready_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt <= 0;
            ready_q   <= 1'b0;
        end else if (!p_en || !model_on) begin
            model_cnt <= 0;
            ready_q   <= 1'b0;
        end else begin
            model_cnt <= model_cnt + 1;
            if (model_cnt == LAT - 1) ready_q <= 1'b1;
        end
    end
    assign p_ready = ready_q;

    always_comb begin
        if (p_in == 25'h0454544) begin
            p_out = 2'b10;
            p_acc = 5'd4;
        end else if (p_in == 25'h1155151) begin
            p_out = 2'b11;
            p_acc = 5'd11;
        end else begin
            p_out = p_in[1:0];
            p_acc = p_in[6:2];
        end
    end

    // Monitor: result log {idx,class,acc,timeout}, done count, p_en run/gap lengths.
    logic [10:0] rv [16];
    int   rv_n, done_n, en_rises, en_len, gap_min, low_run;
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        if (res_valid) begin
            if (rv_n < 16) rv[rv_n] = {res_idx, res_class, res_acc, res_timeout};
            rv_n++;
        end
        if (done) done_n++;
        if (p_en) begin
            if (!en_prev) begin
                en_rises++;
                if (en_rises > 1 && low_run < gap_min) gap_min = low_run;
                en_len = 0;
            end
            en_len++;
        end else begin
            if (en_prev) low_run = 0;
            low_run++;
        end
        en_prev = p_en;
    end

    task automatic clear_mon();
        rv_n = 0; done_n = 0; en_rises = 0; en_len = 0; gap_min = 1000; low_run = 0;
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [24:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_batch(input logic [3:0] n);
        @(negedge clk);
        start = 1'b1; num_patterns = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit expired);
        expired = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int n, input int limit, output bit expired);
        expired = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (en_rises >= n) begin
                expired = 1'b0;
                break;
            end
        end
    endtask

    function automatic logic [24:0] pat(input int i);
        pat = (25'(i) << 10) | (25'(i + 1) << 2) | (((i % 2) == 1) ? 25'd3 : 25'd2);
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, p_en, res_valid, res_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {busy, done, p_en, res_valid, res_timeout});
        end
        checks++;
        if ({p_in, res_idx, res_class, res_acc} !== 35'b0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {p_in, res_idx, res_class, res_acc});
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== 12'b0) begin
            errors++;
            $display("FAIL reset_tallies got %h want 000", {cross_cnt, circle_cnt, err_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_patterns();
        bit to;
        write_slot(3'd0, 25'h0454544);
        write_slot(3'd1, 25'h1155151);
        clear_mon();
        model_on = 1'b1;
        start_batch(4'd2);
        checks++;
        if ({busy, p_en} !== 2'b10) begin
            errors++;
            $display("FAIL two_fetch got busy,p_en=%b want 10", {busy, p_en});
        end
        @(negedge clk);
        checks++;
        if ({p_en, p_in} !== {1'b1, 25'h0454544}) begin
            errors++;
            $display("FAIL two_run_entry got %b/%h want 1/0454544", p_en, p_in);
        end
        wait_idle(200, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL two_finish got busy=1 want idle within 200 cycles");
        end
        checks++;
        if (rv_n !== 2) begin
            errors++;
            $display("FAIL two_count got %0d want 2", rv_n);
        end
        checks++;
        if (rv[0] !== {3'd0, 2'b10, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL two_res0 got %h want %h", rv[0], {3'd0, 2'b10, 5'd4, 1'b0});
        end
        checks++;
        if (rv[1] !== {3'd1, 2'b11, 5'd11, 1'b0}) begin
            errors++;
            $display("FAIL two_res1 got %h want %h", rv[1], {3'd1, 2'b11, 5'd11, 1'b0});
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== {4'd1, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL two_tallies got %h want 110", {cross_cnt, circle_cnt, err_cnt});
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL two_done got %0d want 1", done_n);
        end
        checks++;
        if (gap_min < 2) begin
            errors++;
            $display("FAIL two_en_gap got %0d want >=2", gap_min);
        end
    endtask

    task automatic test_empty();
        clear_mon();
        start_batch(4'd0);
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL empty_done got done,busy=%b want 11", {done, busy});
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL empty_idle got done,busy=%b want 00", {done, busy});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({en_rises, done_n} !== {32'd0, 32'd1}) begin
            errors++;
            $display("FAIL empty_en got rises=%0d dones=%0d want 0/1", en_rises, done_n);
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== 12'b0) begin
            errors++;
            $display("FAIL empty_tallies got %h want 000", {cross_cnt, circle_cnt, err_cnt});
        end
    endtask

    task automatic test_timeout();
        bit to;
        model_on = 1'b0;
        clear_mon();
        start_batch(4'd1);
        wait_idle(300, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL timeout_finish got busy=1 want idle within 300 cycles");
        end
        checks++;
        if ({en_rises, en_len} !== {32'd1, 32'd100}) begin
            errors++;
            $display("FAIL timeout_en_len got rises=%0d len=%0d want 1/100", en_rises, en_len);
        end
        checks++;
        if ({rv_n, rv[0]} !== {32'd1, 3'd0, 2'b00, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_res got n=%0d res=%h want 1/001", rv_n, rv[0]);
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== {4'd0, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL timeout_tallies got %h want 001", {cross_cnt, circle_cnt, err_cnt});
        end
        model_on = 1'b1;
    endtask

    task automatic test_abort();
        bit to;
        write_slot(3'd2, 25'h0000007);
        clear_mon();
        start_batch(4'd3);
        wait_rises(2, 200, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL abort_reach got no second p_en want second pattern in RUN");
        end
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({p_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_stop got p_en,busy=%b want 00", {p_en, busy});
        end
        repeat (30) @(negedge clk);
        checks++;
        if ({rv_n, done_n} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL abort_results got results=%0d dones=%0d want 1/0", rv_n, done_n);
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== {4'd0, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL abort_tallies got %h want 010", {cross_cnt, circle_cnt, err_cnt});
        end
    endtask

    task automatic test_async_reset();
        bit to;
        clear_mon();
        start_batch(4'd2);
        wait_rises(2, 200, to);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p_en, busy, cross_cnt, circle_cnt, err_cnt} !== 14'b0) begin
            errors++;
            $display("FAIL reset_async got %h want 0", {p_en, busy, cross_cnt, circle_cnt, err_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (done_n !== 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d want 0", done_n);
        end
        clear_mon();
        start_batch(4'd1);
        wait_idle(200, to);
        checks++;
        if ({to, rv_n[3:0], rv[0]} !== {1'b0, 4'd1, 3'd0, 2'b10, 5'd4, 1'b0}) begin
            errors++;
            $display("FAIL reset_rerun got to=%b n=%0d res=%h want 0/1/088", to, rv_n, rv[0]);
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt} !== {4'd0, 4'd1, 4'd0}) begin
            errors++;
            $display("FAIL reset_rerun_tallies got %h want 010", {cross_cnt, circle_cnt, err_cnt});
        end
    endtask

    task automatic test_lockout_clamp();
        bit to;
        logic [10:0] exp_rv;
        for (int i = 1; i < 8; i++) write_slot(3'(i), pat(i));
        clear_mon();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = pat(0);
        start = 1'b1; num_patterns = 4'd9;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 25'h1FFFFFF;
        start = 1'b1; num_patterns = 4'd1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_idle(400, to);
        checks++;
        if (to || rv_n !== 8) begin
            errors++;
            $display("FAIL clamp_count got to=%b n=%0d want 0/8", to, rv_n);
        end
        for (int i = 0; i < 8; i++) begin
            exp_rv = {3'(i), ((i % 2) == 1) ? 2'b11 : 2'b10, 5'(i + 1), 1'b0};
            checks++;
            if (rv[i] !== exp_rv) begin
                errors++;
                $display("FAIL clamp_res%0d got %h want %h", i, rv[i], exp_rv);
            end
        end
        checks++;
        if ({cross_cnt, circle_cnt, err_cnt, done_n[3:0]} !== {4'd4, 4'd4, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL clamp_tallies got %h dones=%0d want 440/1",
                     {cross_cnt, circle_cnt, err_cnt}, done_n);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_two_patterns();
        test_empty();
        test_timeout();
        test_abort();
        test_async_reset();
        test_lockout_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
